sd_block_fifo: RTL
==================

// Module: sd_block_fifo
// PURPOSE
//  Byte FIFO between the USB bulk-OUT endpoint and the SD interface write path.
//  - Presents fifo_empty, fifo_full and rd_data to the SD side; the SD side pops with read_fifo.
//  - Counts complete 512-byte blocks so the SD controller starts a block write only when a whole block is buffered.
//  - Supports a block-aligned flush.
// PARAMETERS
//  DEPTH        1024  bytes of storage; power of 2 and a multiple of BLOCK_BYTES
//  BLOCK_BYTES  512   SD block size in bytes; power of 2
// PORTS
//  clk           in   1        system clock
//  rst           in   1        synchronous reset, active-high
//  wr_en         in   1        USB side pushes wr_data this cycle
//  wr_data       in   8        byte from USB side
//  wr_full       out  1        USB-side backpressure; high when full or while flushing
//  read_fifo     in   1        SD side pops the head byte
//  rd_data       out  8        head byte, first-word-fall-through
//  fifo_empty    out  1        no bytes stored
//  fifo_full     out  1        DEPTH bytes stored
//  block_ready   out  1        blocks_avail != 0
//  blocks_avail  out  $clog2(DEPTH/BLOCK_BYTES)+1  complete unread blocks
//  occupancy     out  $clog2(DEPTH)+1              bytes stored
//  flush         in   1        request to discard contents (pulse)
//  flush_done    out  1        one-cycle pulse when the flush completes
// BEHAVIOUR
//  - Reset values: pointers, occupancy, blocks_avail and offsets = 0; fifo_empty=1; all other outputs 0; state=ST_RUN.
//  - Reset applies mid-operation too: all contents are lost.
//  - rd_data = mem[rd_ptr] combinationally, so the byte is valid while fifo_empty=0.
//    rd_ptr advances on the clk edge where read_fifo=1 and fifo_empty=0.
//  - Write is accepted when wr_en=1, fifo_full=0 and state=ST_RUN. Otherwise it is dropped.
//    A write when full is dropped even if a read occurs in the same cycle.
//  - A read when empty is ignored; pointers do not move.
//  - Simultaneous accepted write and read: occupancy unchanged, both pointers advance.
//  - Pointers are AW=$clog2(DEPTH) bits and wrap naturally. Full/empty are derived from occupancy.
//  - wr_off / rd_off are $clog2(BLOCK_BYTES)-bit byte offsets within the current block.
//    An accepted byte at offset BLOCK_BYTES-1 wraps the offset to 0 and raises blk_inc (write side) or blk_dec (read side).
//  - blocks_avail: +1 on blk_inc only, -1 on blk_dec only, unchanged when both occur.
//  - Flags (fifo_empty, fifo_full, block_ready, wr_full) are registered, consistent with occupancy/blocks_avail in the same cycle.
//  - FSM (sd_fifo_pkg::state_t):
//    - ST_RUN: flush=1 and (rd_off==0 or fifo_empty) -> ST_FLUSH. flush=1 otherwise -> ST_FLUSH_WAIT.
//    - ST_FLUSH_WAIT: writes blocked, wr_full=1, reads continue. Go to ST_FLUSH when rd_off==0 or fifo_empty.
//      This keeps a partially transmitted SD block intact.
//    - ST_FLUSH: one cycle. Clear pointers, offsets, occupancy and blocks_avail; pulse flush_done next cycle; -> ST_RUN.
//      read_fifo is ignored in this cycle.
//    - flush asserted outside ST_RUN is ignored.
// CONFIGURATION
//  SD_FIFO_ERR_EN
//  - Defined: adds outputs err_overflow and err_underflow (1 bit each, reset 0).
//    - err_overflow: sticky, set by a dropped write (wr_en while full or not ST_RUN).
//    - err_underflow: sticky, set by read_fifo while empty.
//    - Both are cleared only by rst or completion of ST_FLUSH.
//  - Undefined: these ports and their logic do not exist; dropped operations are silent.
// STRUCTURE
//  - sd_fifo_pkg: state_t enum {ST_RUN, ST_FLUSH_WAIT, ST_FLUSH}; SD_BLOCK_BYTES=512 constant.
//  - Sub-module sd_fifo_mem: DEPTH x 8 register array with synchronous write port and combinational read port.
//    Pointers, counters and FSM stay in sd_block_fifo.
// TESTING
//  1. Reset, then write 512 bytes 0x00..0xFF,0x00..0xFF -> block_ready rises the cycle after byte 512 is accepted; blocks_avail=1, occupancy=512.
//  2. Pop 512 via read_fifo -> rd_data sequence matches; after last pop: blocks_avail=0, fifo_empty=1, block_ready=0.
//  3. Fill 1024 bytes -> fifo_full=1, wr_full=1. Write 0xAA with simultaneous read -> byte dropped, occupancy=1023, err_overflow=1 when SD_FIFO_ERR_EN.
//  4. Concurrent write+read at occupancy 300 for 600 cycles -> occupancy stays 300; pointers wrap past 1023 without data corruption.
//  5. 700 bytes stored, 100 popped, flush -> ST_FLUSH_WAIT; writes dropped; after 412 more pops -> flush_done pulse, occupancy=0, blocks_avail=0.
//  6. rst asserted with occupancy=800, mid-read -> next cycle all outputs at reset values; a following write/read returns the new byte.

Source files
------------

// File: rtl/sd_fifo_pkg.sv
// Shared types and constants for the SD block FIFO.
package sd_fifo_pkg;

  localparam int SD_BLOCK_BYTES = 512;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

endpackage

// File: rtl/sd_fifo_mem.sv
// DEPTH x 8 byte storage: synchronous write port, combinational read port.
module sd_fifo_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sd_block_fifo.sv
// Byte FIFO from USB bulk-OUT to the SD write path with whole-block counting
// and block-aligned flush. Define SD_FIFO_ERR_EN for sticky overflow/underflow flags.
module sd_block_fifo
  import sd_fifo_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int BLOCK_BYTES = SD_BLOCK_BYTES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [7:0]                        wr_data,
  output logic                              wr_full,
  input  logic                              read_fifo,
  output logic [7:0]                        rd_data,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic                              block_ready,
  output logic [$clog2(DEPTH/BLOCK_BYTES):0] blocks_avail,
  output logic [$clog2(DEPTH):0]            occupancy,
  input  logic                              flush,
  output logic                              flush_done,
`ifdef SD_FIFO_ERR_EN
  output logic                              err_overflow,
  output logic                              err_underflow,
`endif
  output state_t                            dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(BLOCK_BYTES);
  localparam int BW = $clog2(DEPTH/BLOCK_BYTES) + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [CW-1:0] occupancy_q, occupancy_d;
  logic [BW-1:0] blocks_q, blocks_d;
  state_t        state_q, state_d;
  logic          fifo_empty_q, fifo_empty_d;
  logic          fifo_full_q, fifo_full_d;
  logic          block_ready_q, block_ready_d;
  logic          wr_full_q, wr_full_d;
  logic          flush_done_q, flush_done_d;
  logic          wr_acc, rd_acc, blk_inc, blk_dec;

  // Handshake: a push completes when wr_en && !wr_full (wr_full covers both
  // full and any flush state); a pop completes when read_fifo && !fifo_empty,
  // except during the single ST_FLUSH cycle. Unaccepted requests are dropped.
  assign wr_acc = wr_en && !wr_full_q;
  assign rd_acc = read_fifo && !fifo_empty_q && (state_q != ST_FLUSH);

  sd_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_off_d    = wr_off_q;
    rd_off_d    = rd_off_q;
    occupancy_d = occupancy_q;
    blocks_d    = blocks_q;
    state_d     = state_q;
    blk_inc     = 1'b0;
    blk_dec     = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      wr_off_d = wr_off_q + OW'(1);
      blk_inc  = (wr_off_q == OW'(BLOCK_BYTES - 1));
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rd_off_d = rd_off_q + OW'(1);
      blk_dec  = (rd_off_q == OW'(BLOCK_BYTES - 1));
    end

    case ({wr_acc, rd_acc})
      2'b10:   occupancy_d = occupancy_q + CW'(1);
      2'b01:   occupancy_d = occupancy_q - CW'(1);
      default: occupancy_d = occupancy_q;
    endcase

    case ({blk_inc, blk_dec})
      2'b10:   blocks_d = blocks_q + BW'(1);
      2'b01:   blocks_d = blocks_q - BW'(1);
      default: blocks_d = blocks_q;
    endcase

    // Flush only at an SD block boundary so a block in flight is never torn.
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ((rd_off_q == '0) || fifo_empty_q) ? ST_FLUSH : ST_FLUSH_WAIT;
        end
      end
      ST_FLUSH_WAIT: begin
        if ((rd_off_q == '0) || fifo_empty_q) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d     = ST_RUN;
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        wr_off_d    = '0;
        rd_off_d    = '0;
        occupancy_d = '0;
        blocks_d    = '0;
      end
      default: state_d = ST_RUN;
    endcase

    fifo_empty_d  = (occupancy_d == '0);
    fifo_full_d   = (occupancy_d == CW'(DEPTH));
    block_ready_d = (blocks_d != '0);
    wr_full_d     = fifo_full_d || (state_d != ST_RUN);
    flush_done_d  = (state_q == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_off_q      <= '0;
      rd_off_q      <= '0;
      occupancy_q   <= '0;
      blocks_q      <= '0;
      state_q       <= ST_RUN;
      fifo_empty_q  <= 1'b1;
      fifo_full_q   <= 1'b0;
      block_ready_q <= 1'b0;
      wr_full_q     <= 1'b0;
      flush_done_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_off_q      <= wr_off_d;
      rd_off_q      <= rd_off_d;
      occupancy_q   <= occupancy_d;
      blocks_q      <= blocks_d;
      state_q       <= state_d;
      fifo_empty_q  <= fifo_empty_d;
      fifo_full_q   <= fifo_full_d;
      block_ready_q <= block_ready_d;
      wr_full_q     <= wr_full_d;
      flush_done_q  <= flush_done_d;
    end
  end

`ifdef SD_FIFO_ERR_EN
  logic err_overflow_q, err_overflow_d, err_underflow_q, err_underflow_d;

  // Completing a flush clears the sticky flags, winning over a same-cycle set.
  always_comb begin
    err_overflow_d  = err_overflow_q || (wr_en && !wr_acc);
    err_underflow_d = err_underflow_q || (read_fifo && fifo_empty_q);
    if (state_q == ST_FLUSH) begin
      err_overflow_d  = 1'b0;
      err_underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
`endif

  assign wr_full      = wr_full_q;
  assign fifo_empty   = fifo_empty_q;
  assign fifo_full    = fifo_full_q;
  assign block_ready  = block_ready_q;
  assign blocks_avail = blocks_q;
  assign occupancy    = occupancy_q;
  assign flush_done   = flush_done_q;
  assign dbg_state    = state_q;

endmodule
